// File: rtl/ntr_command_rx.sv
// ---------------------------------------------------------------------------
// ntr_command_rx
//
// Receives the NTR cartridge command from the host bus one byte per strobe,
// MSB-first, and presents it as a single word with a valid/ack handshake.
// The first received byte lands in the top byte of `cmd`.
//
// Optional feature: define NTR_CMD_DECODE_EN to build the opcode pre-decoder
// that flags the common command classes. Without it the op_* ports are tied
// to 0 and no compare logic exists.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   cs         in   host chip-select, high = command phase active
//   in_valid   in   byte strobe qualifying bus_in
//   bus_in     in   command byte from host
//   cmd        out  assembled command (8*NBYTES bits)
//   cmd_valid  out  cmd holds a complete command
//   cmd_ack    in   consumer has taken cmd (honoured only while cmd_valid)
//   overrun    out  sticky: a byte was dropped while cmd_valid was high
//   short_err  out  one-cycle pulse: cs fell mid-command
//   op_dummy / op_header / op_chipid / op_key1  out  opcode class flags
// ---------------------------------------------------------------------------
module ntr_command_rx #(
    parameter int NBYTES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  in_valid,
    input  logic [7:0]            bus_in,
    output logic [8*NBYTES-1:0]   cmd,
    output logic                  cmd_valid,
    input  logic                  cmd_ack,
    output logic                  overrun,
    output logic                  short_err,
    output logic                  op_dummy,
    output logic                  op_header,
    output logic                  op_chipid,
    output logic                  op_key1
);

    localparam int W   = 8 * NBYTES;
    localparam int SRW = 8 * (NBYTES - 1);
    localparam int CW  = $clog2(NBYTES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SRW-1:0] sr_q, sr_d;
    logic [W-1:0]   cmd_q, cmd_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic           overrun_q, overrun_d;
    logic           short_err_q, short_err_d;

    logic           accept;
    logic           last_byte;
    logic [W-1:0]   full_word;

    assign accept    = cs && in_valid;
    assign last_byte = (cnt_q == CW'(NBYTES - 1));
    // Only the low NBYTES-1 bytes of history ever reach cmd, so the shift
    // register keeps just those; the incoming byte completes the word.
    assign full_word = {sr_q, bus_in};

    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        overrun_d   = overrun_q;
        short_err_d = 1'b0;

        if (accept) begin
            sr_d = full_word[SRW-1:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RECV;
                    cnt_d   = CW'(1);
                end
            end
            ST_RECV: begin
                if (!cs) begin
                    // Host abandoned the command; cmd keeps its old value.
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    short_err_d = 1'b1;
                end else if (accept) begin
                    if (last_byte) begin
                        state_d     = ST_DONE;
                        cnt_d       = '0;
                        cmd_d       = full_word;
                        cmd_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                if (cmd_ack) begin
                    cmd_valid_d = 1'b0;
                    overrun_d   = 1'b0;
                    // A byte arriving with the ack starts the next command.
                    if (accept) begin
                        state_d = ST_RECV;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            short_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            overrun_q   <= overrun_d;
            short_err_q <= short_err_d;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign overrun   = overrun_q;
    assign short_err = short_err_q;

`ifdef NTR_CMD_DECODE_EN
    // Flag order: {dummy, header, chipid, key1}. Loaded alongside cmd so the
    // flags track cmd_valid exactly; the opcodes are distinct, so at most
    // one flag can be set.
    logic [3:0] op_q, op_d;
    logic       load_cmd;
    logic       ack_clear;

    assign load_cmd  = (state_q == ST_RECV) && accept && last_byte;
    assign ack_clear = (state_q == ST_DONE) && cmd_ack;

    always_comb begin
        op_d = op_q;
        if (load_cmd) begin
            case (full_word[W-1 -: 8])
                8'h9F:   op_d = 4'b1000;
                8'h00:   op_d = 4'b0100;
                8'h90:   op_d = 4'b0010;
                8'h3C:   op_d = 4'b0001;
                default: op_d = 4'b0000;
            endcase
        end else if (ack_clear) begin
            op_d = 4'b0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= 4'b0000;
        end else begin
            op_q <= op_d;
        end
    end

    assign {op_dummy, op_header, op_chipid, op_key1} = op_q;
`else
    assign op_dummy  = 1'b0;
    assign op_header = 1'b0;
    assign op_chipid = 1'b0;
    assign op_key1   = 1'b0;
`endif

endmodule

// File: tb/tb_ntr_command_rx.sv
// ---------------------------------------------------------------------------
// tb_ntr_command_rx
//
// Directed scenarios followed by a randomized phase, all checked cycle by
// cycle against a queue-based reference model of the command receiver.
// Define NTR_CMD_DECODE_EN for both bench and RTL to check the op_* flags.
// ---------------------------------------------------------------------------
module tb_ntr_command_rx;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs;
    logic          in_valid;
    logic [7:0]    bus_in;
    logic [63:0]   cmd;
    logic          cmd_valid;
    logic          cmd_ack;
    logic          overrun;
    logic          short_err;
    logic          op_dummy, op_header, op_chipid, op_key1;

    int n_asserts = 0;
    int n_fail    = 0;

    ntr_command_rx #(.NBYTES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .in_valid  (in_valid),
        .bus_in    (bus_in),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ack   (cmd_ack),
        .overrun   (overrun),
        .short_err (short_err),
        .op_dummy  (op_dummy),
        .op_header (op_header),
        .op_chipid (op_chipid),
        .op_key1   (op_key1)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A partial command is simply the list of bytes received so far; a
    // completed command is held until acknowledged.
    logic [7:0]  part[$];
    bit          m_have;
    logic [63:0] m_cmd;
    bit          m_ovr;
    bit          m_short;

    task automatic model_reset();
        part.delete();
        m_have  = 1'b0;
        m_cmd   = '0;
        m_ovr   = 1'b0;
        m_short = 1'b0;
    endtask

    task automatic model_step(input bit c, input bit v, input logic [7:0] b, input bit a);
        logic [63:0] word;
        m_short = 1'b0;
        if (m_have) begin
            if (a) begin
                m_have = 1'b0;
                m_ovr  = 1'b0;
                if (c && v) part.push_back(b);
            end else if (c && v) begin
                m_ovr = 1'b1;
            end
        end else if (part.size() > 0 && !c) begin
            part.delete();
            m_short = 1'b1;
        end else if (c && v) begin
            part.push_back(b);
            if (part.size() == N) begin
                word = '0;
                foreach (part[i]) word = (word << 8) | 64'(part[i]);
                m_cmd  = word;
                m_have = 1'b1;
                part.delete();
            end
        end
    endtask

    function automatic logic [3:0] exp_flags();
        logic [3:0] f;
        f = 4'b0000;
`ifdef NTR_CMD_DECODE_EN
        if (m_have) begin
            if (m_cmd[63:56] == 8'h9F) f = 4'b1000;
            if (m_cmd[63:56] == 8'h00) f = 4'b0100;
            if (m_cmd[63:56] == 8'h90) f = 4'b0010;
            if (m_cmd[63:56] == 8'h3C) f = 4'b0001;
        end
`endif
        return f;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cmd"},       cmd, m_cmd);
        check({tag, ".cmd_valid"}, 64'(cmd_valid), 64'(m_have));
        check({tag, ".overrun"},   64'(overrun),   64'(m_ovr));
        check({tag, ".short_err"}, 64'(short_err), 64'(m_short));
        check({tag, ".op"}, 64'({op_dummy, op_header, op_chipid, op_key1}), 64'(exp_flags()));
    endtask

    // One clock: drive on the falling edge, advance the model at the rising
    // edge, sample 1 ns later.
    task automatic cycle(input string tag, input bit c, input bit v, input logic [7:0] b, input bit a);
        @(negedge clk);
        cs = c; in_valid = v; bus_in = b; cmd_ack = a;
        @(posedge clk);
        model_step(c, v, b, a);
        #1;
        check_all(tag);
    endtask

    task automatic send_cmd(input string tag, input logic [63:0] word);
        logic [63:0] w;
        w = word;
        for (int i = 0; i < N; i++) begin
            cycle(tag, 1'b1, 1'b1, w[63:56], 1'b0);
            w = w << 8;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] held;
        rst = 1'b1; cs = 1'b0; in_valid = 1'b0; bus_in = '0; cmd_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Full command 90 00 .. 00
        send_cmd("full", 64'h9000000000000000);
        check("full.word",  cmd, 64'h9000000000000000);
        check("full.valid", 64'(cmd_valid), 64'd1);
`ifdef NTR_CMD_DECODE_EN
        check("full.chipid", 64'(op_chipid), 64'd1);
`endif

        // Hold five cycles, then a single ack
        for (int i = 0; i < 5; i++) begin
            cycle("hold", 1'b1, 1'b0, 8'hA5, 1'b0);
            check("hold.stable", cmd, 64'h9000000000000000);
        end
        cycle("ack", 1'b1, 1'b0, 8'h00, 1'b1);
        check("ack.valid", 64'(cmd_valid), 64'd0);

        // Abort after three bytes
        cycle("abort", 1'b1, 1'b1, 8'h11, 1'b0);
        cycle("abort", 1'b1, 1'b1, 8'h22, 1'b0);
        cycle("abort", 1'b1, 1'b1, 8'h33, 1'b0);
        cycle("abort.cs", 1'b0, 1'b0, 8'h00, 1'b0);
        check("abort.short", 64'(short_err), 64'd1);
        check("abort.valid", 64'(cmd_valid), 64'd0);
        cycle("abort.after", 1'b0, 1'b1, 8'h44, 1'b0);
        check("abort.pulse1", 64'(short_err), 64'd0);
        send_cmd("after_abort", 64'h9FFFFFFFFFFFFFFF);
        check("after_abort.word", cmd, 64'h9FFFFFFFFFFFFFFF);

        // Overrun: ninth strobe with no ack
        cycle("ovr", 1'b1, 1'b1, 8'h55, 1'b0);
        check("ovr.flag", 64'(overrun), 64'd1);
        check("ovr.cmd",  cmd, 64'h9FFFFFFFFFFFFFFF);
        cycle("ovr.sticky", 1'b0, 1'b0, 8'h00, 1'b0);
        check("ovr.sticky", 64'(overrun), 64'd1);
        cycle("ovr.ack", 1'b1, 1'b0, 8'h00, 1'b1);
        check("ovr.cleared", 64'(overrun), 64'd0);

        // Ack coinciding with the first byte of the next command
        send_cmd("pre_sim", 64'h0123456789ABCDEF);
        cycle("sim", 1'b1, 1'b1, 8'h3C, 1'b1);
        check("sim.valid", 64'(cmd_valid), 64'd0);
        for (int i = 0; i < 7; i++) cycle("sim.rest", 1'b1, 1'b1, 8'(i + 1), 1'b0);
        check("sim.opcode", 64'(cmd[63:56]), 64'h3C);
        check("sim.word", cmd, 64'h3C01020304050607);
`ifdef NTR_CMD_DECODE_EN
        check("sim.key1", 64'(op_key1), 64'd1);
`endif
        cycle("sim.ack", 1'b1, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset after four bytes
        held = cmd;
        for (int i = 0; i < 4; i++) cycle("rstmid", 1'b1, 1'b1, 8'hC0 + 8'(i), 1'b0);
        check("rstmid.before", cmd, held);
        @(negedge clk);
        in_valid = 1'b0; cmd_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("rstmid.async");
        @(negedge clk);
        rst = 1'b0;
        send_cmd("fresh", 64'h00AABBCCDDEEFF11);
        check("fresh.word", cmd, 64'h00AABBCCDDEEFF11);
`ifdef NTR_CMD_DECODE_EN
        check("fresh.header", 64'(op_header), 64'd1);
`endif
        cycle("fresh.ack", 1'b1, 1'b0, 8'h00, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            logic [2:0] sel;
            sel = 3'($urandom_range(0, 7));
            // Bias toward the decoded opcodes so the flags get exercised
            case (sel)
                3'd0: b = 8'h9F;
                3'd1: b = 8'h00;
                3'd2: b = 8'h90;
                3'd3: b = 8'h3C;
                default: b = 8'($urandom);
            endcase
            cycle("rand", ($urandom % 16) != 0, ($urandom % 3) != 0, b, ($urandom % 6) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/ntr_command_rx.md
# ntr_command_rx

Receives the 8-byte NTR cartridge command from the host bus, one byte per strobe, MSB-first, and presents it as a single 64-bit word with a valid/ack handshake. Sits on the cartridge side of the NTR interface, upstream of the command dispatcher. It feeds the byte-wise response path that streams data words back to the host. An optional opcode pre-decoder flags the common command classes.

## Interface
- `NBYTES`, default 8: command length in bytes; legal range 2..16.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cs`  in  1  host chip-select; high = command phase active.
- `in_valid`  in  1  byte strobe; `bus_in` is valid this cycle.
- `bus_in`  in  8  command byte from host.
- `cmd`  out  8*NBYTES  assembled command; first received byte in `cmd[8*NBYTES-1 -: 8]`.
- `cmd_valid`  out  1  `cmd` holds a complete command.
- `cmd_ack`  in  1  consumer has taken `cmd`.
- `overrun`  out  1  sticky: a byte was dropped while `cmd_valid` was high.
- `short_err`  out  1  one-cycle pulse: `cs` fell mid-command.
- `op_dummy`, `op_header`, `op_chipid`, `op_key1`  out  1 each  opcode class flags (see Configuration).

## Operation
- Reset values: `cmd`=0, `cmd_valid`=0, `overrun`=0, `short_err`=0, all `op_*`=0, state IDLE, byte count 0, shift register 0.
- A byte is accepted only when `cs && in_valid` at a rising edge. `in_valid` with `cs` low is ignored.
- The byte counter is `$clog2(NBYTES+1)` bits wide. It counts 0..NBYTES-1 and never wraps past NBYTES-1.
- Shift register: `sr <= {sr[8*NBYTES-9:0], bus_in}` on each accepted byte.
- IDLE:
  - An accepted byte goes to RECV with count=1.
  - If NBYTES were 1 it would go straight to DONE; this is excluded by the legal range.
- RECV:
  - An accepted byte increments the count.
  - When the accepted byte is byte NBYTES, `cmd` loads the full shifted value, `cmd_valid` is set, and the state moves to DONE.
  - `cs` low goes to IDLE, clears the count, and pulses `short_err`; `cmd` is unchanged.
- DONE:
  - `cmd` and `cmd_valid` are held stable.
  - An accepted byte without `cmd_ack` is dropped and sets `overrun`.
  - `cmd_ack` clears `cmd_valid` and `overrun` and goes to IDLE.
  - `cmd_ack` together with an accepted byte takes that byte as byte 1 of the next command and goes to RECV with count=1.
  - `cs` falling in DONE has no effect.
- `cmd_ack` outside DONE is ignored.
- `rst` asserted in any state immediately returns all state and outputs to their reset values. A partial command is discarded.

## Timing
- `cmd_valid` rises on the same edge that captures the last byte and is visible after that edge.
- Latency from the last `in_valid` to `cmd_valid` is 1 edge.
- Back-to-back bytes on consecutive cycles are supported; the throughput limit is 1 byte per clock.
- `cmd_valid` falls on the edge where `cmd_ack` is sampled high.
- `short_err` is high for exactly one cycle, the cycle after the edge where `cs` is sampled low in RECV.
- `overrun` goes high on the edge after the dropped byte and stays high until the acknowledging edge.
- `op_*` flags are registered together with `cmd` and are valid exactly while `cmd_valid` is high.

## Configuration
- Macro `NTR_CMD_DECODE_EN`.
- Defined: on command completion, the opcode `cmd[8*NBYTES-1 -: 8]` is compared and registered:
  - 0x9F sets `op_dummy`.
  - 0x00 sets `op_header`.
  - 0x90 sets `op_chipid`.
  - 0x3C sets `op_key1`.
  - All flags clear on `cmd_ack` or `rst`.
  - At most one flag is high at any time.
- Undefined: all four `op_*` ports exist but are tied to 0, and no compare logic is built.

## Test plan
- Full command: `cs`=1, eight strobes 90 00 00 00 00 00 00 00 on consecutive cycles.
  - Required: `cmd`=0x9000000000000000 and `cmd_valid`=1 after the 8th edge.
  - With the macro defined, `op_chipid`=1.
- Hold and ack: leave the command unacked for 5 cycles, then pulse `cmd_ack` for 1 cycle.
  - Required: `cmd` stays stable throughout the 5 cycles.
  - Required: `cmd_valid`=0 the edge after the ack.
- Abort: 3 bytes are accepted, then `cs`=0.
  - Required: `short_err` pulses for 1 cycle and `cmd_valid` stays 0.
  - Required: a subsequent 8-byte command 9F FF.. is received intact as 0x9FFFFFFFFFFFFFFF.
- Overrun: a 9th strobe arrives while `cmd_valid`=1 with no ack.
  - Required: `overrun`=1 and `cmd` is unchanged.
  - Required: on ack, `overrun`=0.
- Simultaneous: `cmd_ack` and a strobe with 0x3C arrive on the same edge in DONE.
  - Required: `cmd_valid`=0 and the state moves to RECV with count=1.
  - Required: 7 more bytes produce `cmd[63:56]`=0x3C (with the macro, `op_key1`=1).
- Reset mid-command: assert `rst` asynchronously after 4 bytes.
  - Required: all outputs are 0 immediately, without waiting for a clock edge.
  - Required: after release, a fresh 8-byte command is received correctly.
